// File: rtl/if_stage.sv
// if_stage: two-substage instruction fetch with delayed-branch capture, flush redirect and one-outstanding SRAM handshake
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  logic        br_stall, br_taken;
  logic [31:0] br_target;
  logic        fs_valid, pend, buf_valid, bt_valid, bt_due;
  logic [1:0]  discard;
  logic [31:0] fs_pc, inst_buf, bt_reg, nextpc;
  logic        dok, live, fs_leave, capture, use_bt, hs;
  assign {br_stall, br_taken, br_target} = br_bus;
  assign dok            = inst_sram_data_ok & pend;
  assign live           = dok & (discard == 2'd0);
  assign fs_to_ds_valid = !reset & !flush & fs_valid & (discard == 2'd0) & (live | buf_valid);
  assign fs_leave       = fs_to_ds_valid & ds_allowin;
  assign fs_to_ds_bus   = {buf_valid ? inst_buf : inst_sram_rdata, fs_pc};
  assign capture        = br_taken & !br_stall & !bt_valid & !flush;
  assign use_bt         = bt_valid ? bt_due : capture & fs_valid;
  assign nextpc         = flush ? flush_pc : use_bt ? (bt_valid ? bt_reg : br_target) : fs_pc + 32'd4;
  assign inst_sram_req  = !reset & (!pend | dok) & (flush | (!(br_stall & !bt_valid) & (!fs_valid | fs_leave)));
  assign hs             = inst_sram_req & inst_sram_addr_ok;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid  <= 1'b0;
      pend      <= 1'b0;
      buf_valid <= 1'b0;
      bt_valid  <= 1'b0;
      bt_due    <= 1'b0;
      discard   <= 2'd0;
      fs_pc     <= RESET_PC - 32'd4;
    end else begin
      pend      <= hs | (pend & !dok);
      discard   <= discard - {1'b0, dok & (discard != 2'd0)} + {1'b0, flush & pend & !dok & (discard == 2'd0)};
      fs_valid  <= hs | (fs_valid & !fs_leave & !flush);
      fs_pc     <= hs ? nextpc : flush ? flush_pc - 32'd4 : fs_pc;
      buf_valid <= !flush & !fs_leave & (buf_valid | (live & fs_valid));
      bt_valid  <= !flush & (capture | bt_valid) & !(hs & use_bt);
      bt_due    <= capture ? (fs_valid | hs) : (bt_due | hs);
      if (live & !buf_valid) inst_buf <= inst_sram_rdata;
      if (capture) bt_reg <= br_target;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized fetch bench checked against a program-order instruction stream model
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, ds_allowin = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [33:0] br_bus = '0;
  logic        fs_to_ds_valid, inst_sram_req, inst_sram_wr;
  logic [63:0] fs_to_ds_bus;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;
  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc), .ds_allowin(ds_allowin),
    .br_bus(br_bus), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction
  function automatic logic [31:0] pick_pc();
    return ($urandom_range(15) == 0) ? 32'hFFFFFFF8 : {16'hBFC0, 14'($urandom), 2'b00};
  endfunction
  logic [31:0] mq[$];
  logic [31:0] exp_pc = RESET_PC, tgt = '0;
  logic [63:0] prev_bus = '0;
  bit          ds_flag = 0, directed = 1, prev_hold = 0;
  int          bphase = 0, bstall = 0, rst_left = 2, since_rst = 0;
  int          p_addr = 100, p_data = 100, p_allow = 100;
  int          n_deliv = 0, gap = 0, max_gap = 0;
  task automatic drive();
    reset = rst_left > 0;
    if (rst_left > 0) rst_left--;
    flush = 1'b0;
    br_bus = '0;
    ds_allowin = $urandom_range(99) < p_allow;
    if (!reset) begin
      if (bphase == 1) begin
        br_bus = {1'b1, 1'b0, 32'd0};
        ds_allowin = 1'b0;
      end else if (bphase == 2) br_bus = {1'b0, 1'b1, tgt};
      if (!directed && since_rst > 0 && $urandom_range(59) == 0) begin
        flush = 1'b1;
        flush_pc = pick_pc();
      end
    end
    inst_sram_addr_ok = $urandom_range(99) < p_addr;
    inst_sram_data_ok = mq.size() > 0 && $urandom_range(99) < p_data;
    inst_sram_rdata = inst_sram_data_ok ? word(mq[0]) : $urandom;
  endtask
  task automatic observe();
    bit is_ds;
    if (reset) begin
      check("rst_req", inst_sram_req, 0);
      check("rst_valid", fs_to_ds_valid, 0);
      mq.delete();
      exp_pc = RESET_PC;
      ds_flag = 0;
      bphase = 0;
      since_rst = 0;
      prev_hold = 0;
      gap = 0;
      return;
    end
    check("tied", {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb}, 32'h20);
    check("wdata", inst_sram_wdata, 0);
    if (inst_sram_req) check("align", inst_sram_addr[1:0], 0);
    if (since_rst == 0) begin
      check("first_req", inst_sram_req, 1);
      check("first_addr", inst_sram_addr, RESET_PC);
    end
    if (directed && since_rst < 3) begin
      check("seq_req", inst_sram_req, 1);
      check("seq_addr", inst_sram_addr, RESET_PC + 32'(4 * since_rst));
    end
    if (mq.size() > 0 && !inst_sram_data_ok) check("one_outstanding", inst_sram_req, 0);
    if (bphase == 1 && !flush) check("stall_req", inst_sram_req, 0);
    if (flush) begin
      check("flush_valid", fs_to_ds_valid, 0);
      check("flush_addr", inst_sram_addr, flush_pc);
    end
    if (prev_hold && !flush) begin
      check("hold_valid", fs_to_ds_valid, 1);
      check("hold_pc", fs_to_ds_bus[31:0], prev_bus[31:0]);
      check("hold_inst", fs_to_ds_bus[63:32], prev_bus[63:32]);
    end
    prev_hold = fs_to_ds_valid && !ds_allowin;
    prev_bus = fs_to_ds_bus;
    if (bphase == 2) bphase = 0;
    else if (bphase == 1) begin
      bstall--;
      if (bstall == 0) bphase = 2;
    end
    if (fs_to_ds_valid && ds_allowin && !flush) begin
      check("pc", fs_to_ds_bus[31:0], exp_pc);
      check("inst", fs_to_ds_bus[63:32], word(exp_pc));
      n_deliv++;
      gap = 0;
      is_ds = ds_flag;
      if (ds_flag) begin
        exp_pc = tgt;
        ds_flag = 0;
      end else exp_pc = exp_pc + 32'd4;
      if (!is_ds && !directed && bphase == 0 && $urandom_range(4) == 0) begin
        ds_flag = 1;
        tgt = {16'hBFC0, 14'($urandom), 2'b00};
        bstall = $urandom_range(2);
        bphase = (bstall > 0) ? 1 : 2;
      end
    end else begin
      gap++;
      if (gap > max_gap) max_gap = gap;
    end
    if (flush) begin
      exp_pc = flush_pc;
      ds_flag = 0;
      bphase = 0;
    end
    if (inst_sram_data_ok) void'(mq.pop_front());
    if (inst_sram_req && inst_sram_addr_ok) mq.push_back(inst_sram_addr);
    if (mq.size() > 1) check("outstanding_le1", mq.size(), 1);
    since_rst++;
  endtask
  initial begin
    repeat (30) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      observe();
    end
    directed = 0;
    for (int c = 0; c < 9000; c++) begin
      if (c % 1500 == 0) begin
        p_addr = 40 + $urandom_range(60);
        p_data = 30 + $urandom_range(70);
        p_allow = 30 + $urandom_range(70);
      end
      if (rst_left == 0 && $urandom_range(499) == 0) rst_left = 1 + $urandom_range(1);
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      observe();
    end
    check("progress", n_deliv > 500, 1);
    check("max_gap", max_gap < 200, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  exception/eret redirect; one-cycle pulse.
REQ-005 flush_pc  input  32  redirect address, valid while flush=1.
REQ-006 ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-007 br_bus  input  34  {br_stall[33], br_taken[32], br_target[31:0]} driven by decode.
REQ-008 fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction.
REQ-009 fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}.
REQ-010 inst_sram_req  output  1  fetch request.
REQ-011 inst_sram_wr  output  1  tied 0.
REQ-012 inst_sram_size  output  2  tied 2'd2 (word).
REQ-013 inst_sram_addr  output  32  fetch address, word aligned.
REQ-014 inst_sram_wstrb  output  4  tied 0.
REQ-015 inst_sram_wdata  output  32  tied 0.
REQ-016 inst_sram_addr_ok  input  1  request accepted this cycle (req&addr_ok = handshake).
REQ-017 inst_sram_data_ok  input  1  read data returned this cycle, in request order.
REQ-018 inst_sram_rdata  input  32  returned instruction word.

Function
REQ-019 Two sub-stages: pre-IF (address issue) and IF (holds fs_pc, waits for data, presents to decode).
REQ-020 At most one accepted-but-unreturned request outstanding; inst_sram_req=0 while one is outstanding and no data_ok this cycle.
REQ-021 inst_sram_req=1 only when IF stage can take a new pc: IF empty, or IF instruction leaves this cycle (fs_to_ds_valid & ds_allowin).
REQ-022 inst_sram_req=0 while br_stall=1 and a branch target is still needed (target not yet captured).
REQ-023 nextpc priority: flush -> flush_pc; captured branch target due -> bt_reg; else fs_pc+4 (RESET_PC for first fetch).
REQ-024 Branch capture: cycle with br_taken=1, br_stall=0 and bt_valid=0 loads bt_reg<=br_target, bt_valid<=1; br_bus is ignored while bt_valid=1.
REQ-025 Delay slot: if IF holds a valid or outstanding instruction at capture, it is the delay slot and the next request uses bt_reg; if IF is empty, one sequential request (delay slot) is issued first, then bt_reg.
REQ-026 bt_valid clears on the handshake of the request that uses bt_reg.
REQ-027 Instruction buffer: data_ok while fs_to_ds_valid cannot be consumed (ds_allowin=0) stores rdata in inst_buf, buf_valid<=1; output uses inst_buf while buf_valid; buffer clears when decode accepts.
REQ-028 fs_to_ds_valid = IF valid & (data_ok | buf_valid) & no discard pending; fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
REQ-029 IF holds fs_pc and fs_to_ds_bus stable while fs_to_ds_valid=1 and ds_allowin=0.
REQ-030 Flush: same cycle drives nextpc=flush_pc; clears IF valid, buf_valid, bt_valid; if a request is outstanding, discard counter (2 bits) increments.
REQ-031 Discard: each data_ok with discard counter nonzero decrements it and is dropped (never presented, never buffered).
REQ-032 Flush simultaneous with data_ok: returning word is dropped; flush wins over branch capture and any buffered state.
REQ-033 fs_pc+4 is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.

Reset
REQ-034 In any cycle with reset=1: IF valid=0, buf_valid=0, bt_valid=0, discard=0, outstanding=0, fs_to_ds_valid=0, inst_sram_req=0, fs_pc=RESET_PC-4.
REQ-035 First cycle after reset deasserts: inst_sram_req=1, inst_sram_addr=RESET_PC; reset mid-transaction discards all state, late data_ok after reset is ignored.

Verification
REQ-036 Reset release, addr_ok/data_ok=1 every cycle, ds_allowin=1 -> addresses BFC00000, BFC00004, BFC00008 in consecutive cycles; bus pc matches.
REQ-037 ds_allowin=0 for 3 cycles when data for BFC00004 returns -> inst_buf holds word, no new req beyond one outstanding, bus stable, delivered once on allowin.
REQ-038 br_taken=1, br_target=BFC00100 with delay slot BFC00008 in IF -> next addr BFC00100; with IF empty -> BFC00008 then BFC00100.
REQ-039 br_stall=1 for 2 cycles then br_taken=1, target=BFC00200 -> no target request during stall; BFC00200 issued after capture.
REQ-040 flush=1, flush_pc=BFC00380 while request outstanding -> next addr BFC00380; stale data_ok dropped; first presented pc=BFC00380.
REQ-041 flush and data_ok same cycle, plus reset asserted mid-fetch -> no instruction presented; fetch restarts at BFC00380 / RESET_PC respectively.
